ktr_bin_decoder: RTL and testbench
==================================

Name: ktr_bin_decoder

Overview:
- Serial k-th order truncated Rice (TR) debinarizer, the inverse of the KTR binarizer.
- Consumes one bin per handshake, MSB-first, from the CABAC bin decoder (regular or bypass path). Reconstructs symbol value N from the truncated-unary prefix and the K-bit fixed-length suffix.
- Sits between the arithmetic decoder and syntax-element reconstruction.

Parameters:
- BIN_WIDTH, 16, width of cMax and of bin_count_o.
- VALUE_WIDTH, 16, width of reconstructed value N_o and of the internal prefix counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin decode; samples K and cMax.
- K  in  4  Rice parameter (suffix length, 0..15).
- cMax  in  BIN_WIDTH  maximum codable value.
- bin_i  in  1  next bin.
- bin_valid_i  in  1  bin_i valid.
- bin_ready_o  out  1  decoder accepts a bin this cycle.
- N_o  out  VALUE_WIDTH  decoded value.
- done_o  out  1  one-cycle pulse; N_o and bin_count_o valid.
- bin_count_o  out  BIN_WIDTH  number of bins consumed for this symbol.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state IDLE; bin_ready_o=0, done_o=0, N_o=0, bin_count_o=0; internal counters 0.
- start_i (any state, including mid-decode): on the same edge, latch K_r=K and shiftdown_r=cMax>>K; clear the prefix counter, suffix register, suffix bit count and bin count.
  - Next state is PREFIX if shiftdown_r!=0.
  - Otherwise next state is SUFFIX if K!=0.
  - Otherwise next state is FINISH.
  - A start during an in-flight decode aborts it silently, with no done_o for the aborted symbol.
- Bin transfer: occurs when bin_valid_i && bin_ready_o. bin_ready_o=1 only in PREFIX and SUFFIX. Each transfer increments bin_count.
- PREFIX:
  - bin=1: prefix++. If prefix+1==shiftdown_r, the prefix is complete with no terminator. Go to SUFFIX if K_r!=0, else FINISH.
  - bin=0: terminator. Go to SUFFIX if K_r!=0, else FINISH.
  - The prefix never exceeds shiftdown_r, so the counter cannot overflow.
- SUFFIX:
  - Shift in exactly K_r bins: suffix = (suffix<<1)|bin.
  - After the K_r-th bin, go to FINISH.
- FINISH:
  - Register N_o = (prefix<<K_r) | suffix, truncated to VALUE_WIDTH, and bin_count_o = bin_count.
  - Pulse done_o for exactly one cycle, then go to IDLE.
- IDLE: bin_ready_o=0. N_o and bin_count_o hold until the next FINISH.
- Latency:
  - done_o asserts 1 cycle after the accepting edge of the last bin.
  - For cMax>>K==0 with K==0, done_o asserts 2 cycles after start_i and bin_count_o=0.
- Bin stalls: bin_valid_i low stalls indefinitely with state held. Bins offered while bin_ready_o=0 are ignored.
- Simultaneous start_i and a valid bin: start_i wins and the bin is not consumed. bin_ready_o is combinational from state only, so the upstream must not present a bin it needs kept in the start cycle.
- Encoding rules to match:
  - Prefix is unary 1s terminated by 0, unless prefix==cMax>>K, in which case there is no terminator.
  - Suffix is always K bits, MSB-first, even when the prefix is truncated.
  - Total bins = prefix + (terminator?1:0) + K.
- Out-of-range cMax (N > cMax implied) is not checked; the decoded value follows the bit rules above.

Decomposition:
- Shared package ktr_bin_pkg holds:
  - state enum typedef {IDLE, PREFIX, SUFFIX, FINISH};
  - localparam K_WIDTH=4;
  - the rice_k_t typedef, shared with the binarizer.
- Single module, no sub-module. A prefix/suffix datapath split is not warranted at this size.

Test Plan:
- K=2, cMax=15, bins 1,0,1,0 -> done_o, N_o=6, bin_count_o=4.
- K=2, cMax=15, bins 1,1,1,0,1 (truncated prefix, no terminator) -> N_o=13, bin_count_o=5.
- K=0, cMax=4: bins 1,1,1,1 -> N_o=4, count 4. Separately, bins 0 -> N_o=0, count 1.
- K=2, cMax=3 (shiftdown=0), bins 1,0 -> suffix only, N_o=2, count 2. K=0, cMax=0 -> no bins, done_o 2 cycles after start, N_o=0, count 0.
- Backpressure: valid toggled randomly on the first vector, with start_i reissued mid-prefix. Required: aborted symbol produces no done_o; new symbol decodes correctly.
- Async reset asserted mid-SUFFIX -> all outputs 0 immediately, bin_ready_o=0; a decode after reset release is correct.
- Loopback: random K/cMax/N through the KTR binarizer, serialized MSB-first into this block -> N_o==N and bin_count_o==bin_length_o for 10k vectors.

Source files
------------

// File: rtl/ktr_bin_pkg.sv
// rtl/ktr_bin_pkg.sv - shared types for the KTR binarizer/debinarizer pair
package ktr_bin_pkg;

    localparam int K_WIDTH = 4;

    typedef logic [K_WIDTH-1:0] rice_k_t;

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        SUFFIX,
        FINISH
    } ktr_state_e;

endpackage

// File: rtl/ktr_bin_decoder.sv
// rtl/ktr_bin_decoder.sv - serial k-th order truncated Rice debinarizer
module ktr_bin_decoder
    import ktr_bin_pkg::*;
#(
    parameter int BIN_WIDTH   = 16,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  rice_k_t                K,
    input  logic [BIN_WIDTH-1:0]   cMax,
    input  logic                   bin_i,
    input  logic                   bin_valid_i,
    output logic                   bin_ready_o,
    output logic [VALUE_WIDTH-1:0] N_o,
    output logic                   done_o,
    output logic [BIN_WIDTH-1:0]   bin_count_o
);

    ktr_state_e             state_q, state_d;
    rice_k_t                k_q, k_d;
    logic [BIN_WIDTH-1:0]   shiftdown_q, shiftdown_d;
    logic [VALUE_WIDTH-1:0] prefix_q, prefix_d;
    logic [VALUE_WIDTH-1:0] suffix_q, suffix_d;
    logic [K_WIDTH:0]       sfx_cnt_q, sfx_cnt_d;
    logic [BIN_WIDTH-1:0]   bin_count_q, bin_count_d;
    logic [VALUE_WIDTH-1:0] n_q, n_d;
    logic [BIN_WIDTH-1:0]   count_out_q, count_out_d;
    logic                   done_q, done_d;

    logic xfer;
    logic prefix_last;
    logic suffix_last;

    assign bin_ready_o = (state_q == PREFIX) || (state_q == SUFFIX);
    // start_i has priority over a bin in the same cycle, so no transfer is counted then
    assign xfer        = bin_valid_i && bin_ready_o && !start_i;
    assign prefix_last = (32'(prefix_q) + 32'd1) == 32'(shiftdown_q);
    assign suffix_last = (sfx_cnt_q + 1'b1) == {1'b0, k_q};

    assign N_o         = n_q;
    assign bin_count_o = count_out_q;
    assign done_o      = done_q;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        shiftdown_d = shiftdown_q;
        prefix_d    = prefix_q;
        suffix_d    = suffix_q;
        sfx_cnt_d   = sfx_cnt_q;
        bin_count_d = bin_count_q;
        n_d         = n_q;
        count_out_d = count_out_q;
        done_d      = 1'b0;

        if (start_i) begin
            k_d         = K;
            shiftdown_d = cMax >> K;
            prefix_d    = '0;
            suffix_d    = '0;
            sfx_cnt_d   = '0;
            bin_count_d = '0;
            if ((cMax >> K) != '0) begin
                state_d = PREFIX;
            end else if (K != '0) begin
                state_d = SUFFIX;
            end else begin
                state_d = FINISH;
            end
        end else begin
            case (state_q)
                PREFIX: begin
                    if (xfer) begin
                        bin_count_d = bin_count_q + 1'b1;
                        if (bin_i) begin
                            prefix_d = prefix_q + 1'b1;
                            if (prefix_last) begin
                                state_d = (k_q != '0) ? SUFFIX : FINISH;
                            end
                        end else begin
                            state_d = (k_q != '0) ? SUFFIX : FINISH;
                        end
                    end
                end
                SUFFIX: begin
                    if (xfer) begin
                        bin_count_d = bin_count_q + 1'b1;
                        suffix_d    = {suffix_q[VALUE_WIDTH-2:0], bin_i};
                        sfx_cnt_d   = sfx_cnt_q + 1'b1;
                        if (suffix_last) begin
                            state_d = FINISH;
                        end
                    end
                end
                FINISH: begin
                    n_d         = (prefix_q << k_q) | suffix_q;
                    count_out_d = bin_count_q;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            shiftdown_q <= '0;
            prefix_q    <= '0;
            suffix_q    <= '0;
            sfx_cnt_q   <= '0;
            bin_count_q <= '0;
            n_q         <= '0;
            count_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            shiftdown_q <= shiftdown_d;
            prefix_q    <= prefix_d;
            suffix_q    <= suffix_d;
            sfx_cnt_q   <= sfx_cnt_d;
            bin_count_q <= bin_count_d;
            n_q         <= n_d;
            count_out_q <= count_out_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ktr_bin_decoder.sv
// tb/tb_ktr_bin_decoder.sv - scoreboard bench for ktr_bin_decoder
module tb_ktr_bin_decoder;
    import ktr_bin_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    rice_k_t     K;
    logic [15:0] cMax;
    logic        bin_i;
    logic        bin_valid_i;
    logic        bin_ready_o;
    logic [15:0] N_o;
    logic        done_o;
    logic [15:0] bin_count_o;

    ktr_bin_decoder #(.BIN_WIDTH(16), .VALUE_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .K           (K),
        .cMax        (cMax),
        .bin_i       (bin_i),
        .bin_valid_i (bin_valid_i),
        .bin_ready_o (bin_ready_o),
        .N_o         (N_o),
        .done_o      (done_o),
        .bin_count_o (bin_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done N_o=%0d bin_count_o=%0d required no done_o", N_o, bin_count_o);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (N_o !== 16'(mon_e.n)) begin
                    errors++;
                    $display("FAIL n_value actual=%0d required=%0d", N_o, mon_e.n);
                end
                checks++;
                if (bin_count_o !== 16'(mon_e.cnt)) begin
                    errors++;
                    $display("FAIL bin_count actual=%0d required=%0d", bin_count_o, mon_e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: the KTR binarizer rules applied directly to N.
    task automatic encode(input int k, input int cmax, input int n, output logic [63:0] bits, output int nb);
        int sd;
        int p;
        sd   = cmax >> k;
        p    = n >> k;
        bits = '0;
        nb   = 0;
        for (int i = 0; i < p; i++) begin
            bits = {bits[62:0], 1'b1};
            nb++;
        end
        if (p < sd) begin
            bits = {bits[62:0], 1'b0};
            nb++;
        end
        for (int i = k - 1; i >= 0; i--) begin
            bits = {bits[62:0], 1'((n >> i) & 1)};
            nb++;
        end
    endtask

    task automatic start_sym(input int k, input int cmax);
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        K           = rice_k_t'(k);
        cMax        = 16'(cmax);
        bin_valid_i = 1'($urandom);
        bin_i       = 1'($urandom);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        bin_valid_i = 1'b0;
    endtask

    task automatic feed_bits(input logic [63:0] bits, input int nbits, input bit stall);
        int t;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (stall) begin
                while ($urandom_range(2) == 0) begin
                    bin_valid_i = 1'b0;
                    bin_i       = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            bin_i       = bits[i];
            bin_valid_i = 1'b1;
            t = 0;
            while (!bin_ready_o && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 50) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout actual=0 required=1");
                bin_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bin_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_sym(input int k, input int cmax, input logic [63:0] bits, input int nbits,
                           input int expn, input int expcnt, input bit stall);
        exp_q.push_back('{expn, expcnt});
        start_sym(k, cmax);
        feed_bits(bits, nbits, stall);
        @(negedge clk);
        chk("done_early", int'(done_o), 0);
        @(negedge clk);
        chk("done_latency", int'(done_o), 1);
        wait_drain();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        int          nb;
        int          k;
        int          cmax;
        int          sd;
        int          sd_lim;
        int          n;

        rst_n       = 1'b0;
        start_i     = 1'b0;
        K           = '0;
        cMax        = '0;
        bin_i       = 1'b0;
        bin_valid_i = 1'b0;
        #2;
        chk("reset_ready", int'(bin_ready_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_n", int'(N_o), 0);
        chk("reset_count", int'(bin_count_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_sym(2, 15, 64'b1010, 4, 6, 4, 1'b0);
        run_sym(2, 15, 64'b11101, 5, 13, 5, 1'b0);
        run_sym(0, 4, 64'b1111, 4, 4, 4, 1'b0);
        run_sym(0, 4, 64'b0, 1, 0, 1, 1'b0);
        run_sym(2, 3, 64'b10, 2, 2, 2, 1'b0);
        run_sym(0, 0, 64'b0, 0, 0, 0, 1'b0);

        // abort mid-prefix, restart with a stalled stream
        start_sym(2, 15);
        feed_bits(64'b11, 2, 1'b1);
        run_sym(2, 15, 64'b1010, 4, 6, 4, 1'b1);

        // abort while the first symbol sits in FINISH
        exp_q.push_back('{13, 5});
        @(posedge clk);
        #1;
        start_i = 1'b1;
        K       = 4'd0;
        cMax    = 16'd0;
        @(posedge clk);
        #1;
        K       = 4'd2;
        cMax    = 16'd15;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        feed_bits(64'b11101, 5, 1'b0);
        wait_drain();

        // async reset mid-SUFFIX
        start_sym(3, 15);
        feed_bits(64'b11, 2, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", int'(bin_ready_o), 0);
        chk("rst_mid_done", int'(done_o), 0);
        chk("rst_mid_n", int'(N_o), 0);
        chk("rst_mid_count", int'(bin_count_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_sym(3, 15, 64'b1101, 4, 13, 4, 1'b0);

        for (int v = 0; v < 300; v++) begin
            k      = int'($urandom_range(15));
            sd_lim = 65535 >> k;
            if (sd_lim > 20) sd_lim = 20;
            sd     = int'($urandom_range(sd_lim));
            cmax   = (sd << k) | (int'($urandom) & ((1 << k) - 1));
            n      = int'($urandom_range(cmax));
            encode(k, cmax, n, bits, nb);
            run_sym(k, cmax, bits, nb, n, nb, 1'($urandom));
        end

        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
